// File: rtl/elpis_uart_tx.sv
// elpis_uart_tx: byte FIFO feeding an 8N1 UART transmitter.
// Ports:
//   wb_clk_i, wb_rst_i         clock, sync active-high reset
//   en_i                       transmit enable (frame in flight always completes)
//   wr_valid_i/wr_data_i       byte write from the core
//   wr_ready_o                 FIFO not full
//   tx_o, tx_oeb_o             serial line (idle high), pad OE (active low)
//   busy_o                     frame in progress or bytes queued
//   tx_done_o                  one-cycle pulse in the last stop-bit cycle
//   overflow_o                 sticky: write presented while full
//   fifo_cnt_o                 bytes queued
module elpis_uart_tx #(
    parameter int CLKS_PER_BIT = 2083,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        en_i,
    input  logic                        wr_valid_i,
    input  logic [7:0]                  wr_data_i,
    output logic                        wr_ready_o,
    output logic                        tx_o,
    output logic                        tx_oeb_o,
    output logic                        busy_o,
    output logic                        tx_done_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          tick;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    assign fifo_empty = (cnt == '0);
    assign wr_ready_o = (cnt != CNT_FULL);
    assign push       = wr_valid_i && wr_ready_o;
    assign tick       = (baud == BAUD_MAX);
    assign fifo_cnt_o = cnt;
    assign busy_o     = (state != IDLE) || !fifo_empty;
    assign tx_done_o  = (state == STOP) && tick;

    // Storage carries no reset; validity is tracked by cnt.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!push && pop) begin
                cnt <= cnt - CW'(1);
            end
            if (wr_valid_i && !wr_ready_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
            tx_oeb_o <= 1'b1;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            idx      <= idx_n;
            shift    <= shift_n;
            tx_o     <= tx_n;
            tx_oeb_o <= ~en_i;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;

        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (en_i && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                baud_n = tick ? '0 : baud + BW'(1);
                if (tick) begin
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                baud_n = tick ? '0 : baud + BW'(1);
                if (tick) begin
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                baud_n = tick ? '0 : baud + BW'(1);
                if (tick) begin
                    // Chain straight into the next start bit.
                    if (en_i && !fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Line level is decided from the next state so tx_o is a flop.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_elpis_uart_tx.sv
// tb_elpis_uart_tx: scoreboard bench for elpis_uart_tx.
// A line monitor decodes 8N1 frames and pops expected bytes.
module tb_elpis_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       tx;
    logic       oeb;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [2:0] cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int rst_gen = 0;
    int starts[$];
    logic [8:0] sb[$];

    elpis_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .en_i      (en),
        .wr_valid_i(wr_valid),
        .wr_data_i (wr_data),
        .wr_ready_o(wr_ready),
        .tx_o      (tx),
        .tx_oeb_o  (oeb),
        .busy_o    (busy),
        .tx_done_o (done),
        .overflow_o(ovf),
        .fifo_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, output logic acc);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        acc = wr_ready;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (acc) sb.push_back({1'b0, b});
    endtask

    task automatic drain(input string tag, input int lim,
                         output int peak);
        int n;
        logic stuck;
        n = 0;
        peak = 0;
        while ((sb.size() != 0 || busy) && n < lim) begin
            @(negedge clk);
            if (int'(cnt) > peak) peak = int'(cnt);
            n++;
        end
        stuck = (sb.size() != 0) || busy;
        check({tag, "_drain"}, 32'(stuck), 0);
        @(posedge clk);
        #1;
    endtask

    // Line monitor: find start, sample mid-bit, compare to scoreboard.
    initial begin
        int g;
        int st;
        logic s_bit;
        logic p_bit;
        logic [7:0] rx;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                g  = rst_gen;
                st = cyc;
                repeat (2) @(negedge clk);
                s_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    rx[i] = tx;
                end
                repeat (C) @(negedge clk);
                p_bit = tx;
                if (g == rst_gen) begin
                    frames++;
                    starts.push_back(st);
                    exp = (sb.size() > 0) ? sb.pop_front() : 9'h100;
                    check("mon_start", 32'(s_bit), 0);
                    check("mon_stop", 32'(p_bit), 1);
                    check("mon_byte", {23'd0, 1'b0, rx}, 32'(exp));
                end
            end
        end
    end

    initial begin
        logic acc;
        int e;
        int t;
        int pk;
        int f0;
        int s0;
        int n;
        int lows;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_oeb", 32'(oeb), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_ready", 32'(wr_ready), 1);

        // Single byte, latency and done timing.
        en = 1'b1;
        @(negedge clk);
        check("t1_oeb", 32'(oeb), 0);
        @(posedge clk);
        #1;
        push(8'h55, acc);
        e = cyc;
        check("t1_acc", 32'(acc), 1);
        @(negedge clk);
        check("t1_tx_hold", 32'(tx), 1);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 0);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        check("t1_done_at", 32'(t - e), 40);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 0);
        check("t1_busy_off", 32'(busy), 0);
        drain("t1", 20, pk);

        // Back-to-back frames.
        s0 = starts.size();
        push(8'h41, acc);
        push(8'h42, acc);
        push(8'h43, acc);
        drain("t2", 300, pk);
        check("t2_peak", 32'(pk), 2);
        check("t2_frames", 32'(starts.size() - s0), 3);
        if (starts.size() >= s0 + 3) begin
            check("t2_gap1", 32'(starts[s0+1] - starts[s0]), 40);
            check("t2_gap2", 32'(starts[s0+2] - starts[s0+1]), 40);
        end

        // Overflow while disabled.
        en = 1'b0;
        f0 = frames;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'h10 + 8'(i), acc);
            n += int'(acc);
        end
        check("t3_accepted", 32'(n), 4);
        @(negedge clk);
        check("t3_ready", 32'(wr_ready), 0);
        check("t3_ovf", 32'(ovf), 1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("t3_idle_line", 32'(lows), 0);
        check("t3_cnt", 32'(cnt), 4);
        @(posedge clk);
        #1;
        en = 1'b1;
        drain("t3", 400, pk);
        check("t3_sent", 32'(frames - f0), 4);

        // Disable mid-frame.
        f0 = frames;
        push(8'hA5, acc);
        push(8'h3C, acc);
        repeat (10) @(posedge clk);
        #1;
        en = 1'b0;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                t = i;
                break;
            end
        end
        check("t4_done_seen", 32'(t >= 0), 1);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("t4_idle_line", 32'(lows), 0);
        check("t4_cnt", 32'(cnt), 1);
        check("t4_one_sent", 32'(frames - f0), 1);
        @(posedge clk);
        #1;
        en = 1'b1;
        drain("t4", 200, pk);
        check("t4_both_sent", 32'(frames - f0), 2);

        // Reset mid-DATA.
        push(8'h81, acc);
        push(8'h7E, acc);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        rst_gen++;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        f0 = frames;
        @(negedge clk);
        check("t5_tx", 32'(tx), 1);
        check("t5_cnt", 32'(cnt), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ovf", 32'(ovf), 0);
        check("t5_ready", 32'(wr_ready), 1);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("t5_idle_line", 32'(lows), 0);
        check("t5_no_frames", 32'(frames - f0), 0);

        // Write while full in the popping STOP cycle.
        @(posedge clk);
        #1;
        f0 = frames;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            push(8'h60 + 8'(i), acc);
            if (i == 0) e = cyc;
            n += int'(acc);
        end
        check("t6_accepted", 32'(n), 5);
        repeat (36) @(posedge clk);
        #1;
        check("t6_align", 32'(cyc - e), 40);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(negedge clk);
        check("t6_done", 32'(done), 1);
        check("t6_ready", 32'(wr_ready), 0);
        check("t6_ovf_pre", 32'(ovf), 0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("t6_ovf", 32'(ovf), 1);
        check("t6_cnt", 32'(cnt), 3);
        @(posedge clk);
        #1;
        push(8'h99, acc);
        check("t6_next_acc", 32'(acc), 1);
        drain("t6", 400, pk);
        check("t6_sent", 32'(frames - f0), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
